fsm_escribir: RTL and testbench

//  Sequencer that drives the 5-bit write-control code ctrl_E into the write decoder.
//  It steps through the RTC write sequence: seconds, minutes, hours (24h or 12h),
//  day, month and year, then optionally the timer seconds, minutes and hours.

---
 rtl/rtc_pkg.sv | 44 ++++
 rtl/escribir_watchdog.sv | 29 ++
 rtl/fsm_escribir.sv | 120 ++++++++++++
 tb/tb_fsm_escribir.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared RTC write-control codes: the sequencer and the write decoder both
// import these so the ctrl_E encoding is defined in exactly one place.
package rtc_pkg;

   localparam int CTRL_E_W = 5;

   localparam logic [CTRL_E_W-1:0] ST_A = 5'd0;
   localparam logic [CTRL_E_W-1:0] ST_B = 5'd1;
   localparam logic [CTRL_E_W-1:0] ST_C = 5'd2;
   localparam logic [CTRL_E_W-1:0] ST_D = 5'd3;
   localparam logic [CTRL_E_W-1:0] ST_E = 5'd4;
   localparam logic [CTRL_E_W-1:0] ST_F = 5'd5;
   localparam logic [CTRL_E_W-1:0] ST_G = 5'd6;
   localparam logic [CTRL_E_W-1:0] ST_H = 5'd7;
   localparam logic [CTRL_E_W-1:0] ST_I = 5'd8;
   localparam logic [CTRL_E_W-1:0] ST_J = 5'd9;
   localparam logic [CTRL_E_W-1:0] ST_K = 5'd10;
   localparam logic [CTRL_E_W-1:0] ST_L = 5'd11;
   localparam logic [CTRL_E_W-1:0] ST_M = 5'd12;
   localparam logic [CTRL_E_W-1:0] ST_N = 5'd13;
   localparam logic [CTRL_E_W-1:0] ST_O = 5'd14;
   localparam logic [CTRL_E_W-1:0] ST_P = 5'd15;
   localparam logic [CTRL_E_W-1:0] ST_Q = 5'd16;
   localparam logic [CTRL_E_W-1:0] ST_R = 5'd17;
   localparam logic [CTRL_E_W-1:0] ST_S = 5'd18;
   localparam logic [CTRL_E_W-1:0] ST_T = 5'd19;
   localparam logic [CTRL_E_W-1:0] ST_U = 5'd20;
   localparam logic [CTRL_E_W-1:0] ST_V = 5'd21;
   localparam logic [CTRL_E_W-1:0] ST_W = 5'd22;
   localparam logic [CTRL_E_W-1:0] ST_X = 5'd23;
   localparam logic [CTRL_E_W-1:0] ST_Y = 5'd24;

   // Data states are the ones that wait for the bus transaction to finish.
   function automatic logic is_data_state(input logic [CTRL_E_W-1:0] s);
      logic r;
      r = 1'b0;
      case (s)
         ST_C, ST_E, ST_G, ST_Y, ST_I, ST_K, ST_M, ST_P, ST_R, ST_T: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/escribir_watchdog.sv
// Per-field bus_done watchdog: counts cycles spent in a data state and flags
// expiry on the TIMEOUT_CYC-th cycle. Only instantiated with ESCRIBIR_TIMEOUT_EN.
module escribir_watchdog #(
   parameter int TIMEOUT_CYC = 255,
   parameter int TO_W        = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] cnt_reg;

   // cnt_reg holds (cycles already spent in the data state); the final cycle is TIMEOUT_CYC-1.
   assign expired = en && (cnt_reg == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (clear) begin
         cnt_reg <= '0;
      end else if (en && !expired) begin
         cnt_reg <= cnt_reg + TO_W'(1);
      end
   end

endmodule

// File: rtl/fsm_escribir.sv
// RTC write sequencer: walks the write fields and drives ctrl_E to the write decoder.
// Optional per-field bus_done timeout is enabled with `define ESCRIBIR_TIMEOUT_EN.
module fsm_escribir
   import rtc_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int TO_W        = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_E,
   input  logic                fmt_12h,
   input  logic                wr_timer,
   input  logic                bus_done,
   input  logic                abort,
   output logic [CTRL_E_W-1:0] ctrl_E,
   output logic                busy,
   output logic                err_to
);

   logic [CTRL_E_W-1:0] state_reg, state_next;
   logic                in_data;
   logic                timed_out;

   assign in_data = is_data_state(state_reg);
   assign ctrl_E  = state_reg;
   assign busy    = (state_reg != ST_A);

`ifdef ESCRIBIR_TIMEOUT_EN
   logic expired;
   logic err_to_reg, err_to_next;

   escribir_watchdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .TO_W       (TO_W)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (!in_data),
      .en     (in_data),
      .expired(expired)
   );

   // bus_done arriving on the last allowed cycle still counts as success.
   assign timed_out = expired && !bus_done;

   always_comb begin
      err_to_next = err_to_reg;
      if (state_reg == ST_A && start_E) begin
         err_to_next = 1'b0;
      end else if (timed_out && !abort) begin
         err_to_next = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_to_reg <= 1'b0;
      end else begin
         err_to_reg <= err_to_next;
      end
   end

   assign err_to = err_to_reg;
`else
   logic unused_cfg;
   assign unused_cfg = ^{TIMEOUT_CYC, TO_W};
   assign timed_out  = 1'b0;
   assign err_to     = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_A: if (start_E) state_next = ST_B;
         ST_B: state_next = ST_C;
         ST_C: if (bus_done) state_next = ST_D;
         ST_D: state_next = ST_E;
         ST_E: if (bus_done) state_next = fmt_12h ? ST_X : ST_F;
         ST_F: state_next = ST_G;
         ST_G: if (bus_done) state_next = ST_H;
         ST_X: state_next = ST_Y;
         ST_Y: if (bus_done) state_next = ST_H;
         ST_H: state_next = ST_I;
         ST_I: if (bus_done) state_next = ST_J;
         ST_J: state_next = ST_K;
         ST_K: if (bus_done) state_next = ST_L;
         ST_L: state_next = ST_M;
         ST_M: if (bus_done) state_next = ST_N;
         ST_N: state_next = wr_timer ? ST_O : ST_U;
         ST_O: state_next = ST_P;
         ST_P: if (bus_done) state_next = ST_Q;
         ST_Q: state_next = ST_R;
         ST_R: if (bus_done) state_next = ST_S;
         ST_S: state_next = ST_T;
         ST_T: if (bus_done) state_next = ST_U;
         ST_U: state_next = ST_V;
         ST_V: state_next = ST_W;
         // Wait for start_E to drop so a held request cannot retrigger.
         ST_W: if (!start_E) state_next = ST_A;
         default: state_next = ST_V;
      endcase

      if (in_data && timed_out) begin
         state_next = ST_V;
      end
      if (abort && state_reg != ST_A && state_reg != ST_W) begin
         state_next = ST_V;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_A;
      end else begin
         state_reg <= state_next;
      end
   end

endmodule

// File: tb/tb_fsm_escribir.sv
// Self-checking bench for fsm_escribir: randomized write sequences checked against
// a field-list schedule model, plus abort, reset, timeout and ignored-input scenarios.
module tb_fsm_escribir;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_E;
   logic       fmt_12h;
   logic       wr_timer;
   logic       bus_done;
   logic       abort;
   logic [4:0] ctrl_E;
   logic       busy;
   logic       err_to;

   int checks = 0;
   int errors = 0;

   fsm_escribir #(
      .TIMEOUT_CYC(4),
      .TO_W       (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start_E (start_E),
      .fmt_12h (fmt_12h),
      .wr_timer(wr_timer),
      .bus_done(bus_done),
      .abort   (abort),
      .ctrl_E  (ctrl_E),
      .busy    (busy),
      .err_to  (err_to)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   // Fields that wait for a bus transaction before moving on.
   function automatic bit is_data_code(input logic [4:0] c);
      return c inside {5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd15, 5'd17, 5'd19, 5'd24};
   endfunction

   task automatic apply_reset();
      reset = 1'b1; start_E = 1'b0; fmt_12h = 1'b0; wr_timer = 1'b0;
      bus_done = 1'b0; abort = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Drive toward a target code with bus_done always high; stops at the negedge where it is seen.
   task automatic goto_code(input logic [4:0] target, input bit fmt, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 80; k++) begin
         if (ctrl_E === target) begin
            ok = 1'b1;
            break;
         end
         start_E = 1'b1; bus_done = 1'b1; fmt_12h = fmt; wr_timer = 1'b1; abort = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         $display("FAIL goto_%0d: ctrl_E=%0d never reached %0d", target, ctrl_E, target);
         errors++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start_E = 1'b1; fmt_12h = 1'b0; wr_timer = 1'b0;
      bus_done = 1'b1; abort = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd0) begin $display("FAIL reset_ctrl: got %0d want 0", ctrl_E); errors++; end
      checks++;
      if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); errors++; end
      checks++;
      if (err_to !== 1'b0) begin $display("FAIL reset_err: got %b want 0", err_to); errors++; end
      start_E = 1'b0; bus_done = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd0) begin $display("FAIL reset_idle: got %0d want 0", ctrl_E); errors++; end
      $display("test_reset done");
   endtask

   // Reference schedule: ordered field list, each data field held d+1 cycles ending in bus_done.
   task automatic run_sequence(input string name, input bit fmt, input bit tmr,
                               input int min_d, input int max_d, input int hold);
      logic [4:0] fields[$];
      logic [4:0] code_q[$];
      bit         bd_q[$];
      bit         st_q[$];
      int         bad;
      int         d;
      apply_reset();
      fields.push_back(5'd1); fields.push_back(5'd2); fields.push_back(5'd3); fields.push_back(5'd4);
      if (fmt) begin fields.push_back(5'd23); fields.push_back(5'd24); end
      else     begin fields.push_back(5'd5);  fields.push_back(5'd6);  end
      for (int c = 7; c <= 13; c++) fields.push_back(5'(c));
      if (tmr) for (int c = 14; c <= 19; c++) fields.push_back(5'(c));
      fields.push_back(5'd20); fields.push_back(5'd21);

      code_q.push_back(5'd0); bd_q.push_back(1'($urandom_range(0, 1))); st_q.push_back(1'b1);
      foreach (fields[j]) begin
         if (is_data_code(fields[j])) begin
            d = $urandom_range(min_d, max_d);
            for (int r = 0; r < d; r++) begin
               code_q.push_back(fields[j]); bd_q.push_back(1'b0); st_q.push_back(1'($urandom_range(0, 1)));
            end
            code_q.push_back(fields[j]); bd_q.push_back(1'b1); st_q.push_back(1'($urandom_range(0, 1)));
         end else begin
            code_q.push_back(fields[j]); bd_q.push_back(1'($urandom_range(0, 1)));
            st_q.push_back(1'($urandom_range(0, 1)));
         end
      end
      for (int r = 0; r < hold; r++) begin
         code_q.push_back(5'd22); bd_q.push_back(1'($urandom_range(0, 1))); st_q.push_back(1'b1);
      end
      code_q.push_back(5'd22); bd_q.push_back(1'($urandom_range(0, 1))); st_q.push_back(1'b0);

      bad = 0;
      foreach (code_q[i]) begin
         checks++;
         if (ctrl_E !== code_q[i]) begin
            $display("FAIL %s_ctrl cyc%0d: got %0d want %0d", name, i, ctrl_E, code_q[i]);
            errors++; bad++;
            break;
         end
         checks++;
         if (busy !== (code_q[i] != 5'd0)) begin
            $display("FAIL %s_busy cyc%0d: got %b want %b", name, i, busy, code_q[i] != 5'd0);
            errors++; bad++;
         end
         if (i > 0) begin
            checks++;
            if (err_to !== 1'b0) begin
               $display("FAIL %s_err cyc%0d: got %b want 0", name, i, err_to); errors++; bad++;
            end
         end
         start_E  = st_q[i];
         bus_done = bd_q[i];
         abort    = 1'b0;
         fmt_12h  = (code_q[i] == 5'd4)  ? fmt : 1'($urandom_range(0, 1));
         wr_timer = (code_q[i] == 5'd13) ? tmr : 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      if (bad == 0) begin
         checks++;
         if (ctrl_E !== 5'd0 || busy !== 1'b0) begin
            $display("FAIL %s_end: ctrl_E=%0d busy=%b want 0/0", name, ctrl_E, busy); errors++; bad++;
         end
      end
      start_E = 1'b0; bus_done = 1'b0;
      $display("run %s fmt12=%0d timer=%0d hold=%0d cycles=%0d errs=%0d",
               name, fmt, tmr, hold, code_q.size(), bad);
   endtask

   task automatic test_abort();
      bit ok;
      apply_reset();
      goto_code(5'd8, 1'b0, ok);
      abort = 1'b1; bus_done = 1'b1; start_E = 1'b0;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd21) begin $display("FAIL abort_data: got %0d want 21", ctrl_E); errors++; end
      abort = 1'b0; bus_done = 1'b0;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd22) begin $display("FAIL abort_v_to_w: got %0d want 22", ctrl_E); errors++; end
      start_E = 1'b1; abort = 1'b1;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd22) begin $display("FAIL abort_in_w: got %0d want 22", ctrl_E); errors++; end
      abort = 1'b0; start_E = 1'b0;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd0) begin $display("FAIL abort_w_release: got %0d want 0", ctrl_E); errors++; end
      abort = 1'b1; start_E = 1'b1;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd1) begin $display("FAIL abort_in_a: got %0d want 1", ctrl_E); errors++; end
      start_E = 1'b0;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd21) begin $display("FAIL abort_load: got %0d want 21", ctrl_E); errors++; end
      abort = 1'b0;
      $display("test_abort done");
   endtask

   task automatic test_async_reset();
      bit ok;
      apply_reset();
      goto_code(5'd16, 1'b1, ok);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (ctrl_E !== 5'd0) begin $display("FAIL async_reset_ctrl: got %0d want 0", ctrl_E); errors++; end
      checks++;
      if (busy !== 1'b0) begin $display("FAIL async_reset_busy: got %b want 0", busy); errors++; end
      @(negedge clk);
      reset = 1'b0; start_E = 1'b0; bus_done = 1'b0;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd0) begin $display("FAIL async_reset_idle: got %0d want 0", ctrl_E); errors++; end
      $display("test_async_reset done");
   endtask

   task automatic test_ignored();
      bit ok;
      apply_reset();
      goto_code(5'd1, 1'b0, ok);
      bus_done = 1'b1; start_E = 1'b0;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd2) begin $display("FAIL ignored_load: got %0d want 2", ctrl_E); errors++; end
      bus_done = 1'b0;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd2) begin $display("FAIL ignored_not_stored: got %0d want 2", ctrl_E); errors++; end
      $display("test_ignored done");
   endtask

   task automatic test_timeout();
      bit ok;
      apply_reset();
      goto_code(5'd2, 1'b0, ok);
      bus_done = 1'b0; start_E = 1'b0;
`ifdef ESCRIBIR_TIMEOUT_EN
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (ctrl_E !== 5'd2 || err_to !== 1'b0) begin
            $display("FAIL timeout_wait%0d: ctrl_E=%0d err_to=%b want 2/0", k, ctrl_E, err_to); errors++;
         end
      end
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd21 || err_to !== 1'b1) begin
         $display("FAIL timeout_fire: ctrl_E=%0d err_to=%b want 21/1", ctrl_E, err_to); errors++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd0 || err_to !== 1'b1) begin
         $display("FAIL timeout_sticky: ctrl_E=%0d err_to=%b want 0/1", ctrl_E, err_to); errors++;
      end
      start_E = 1'b1;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd1 || err_to !== 1'b0) begin
         $display("FAIL timeout_clear: ctrl_E=%0d err_to=%b want 1/0", ctrl_E, err_to); errors++;
      end
      apply_reset();
      goto_code(5'd4, 1'b0, ok);
      bus_done = 1'b0; start_E = 1'b0;
      repeat (3) @(negedge clk);
      bus_done = 1'b1; fmt_12h = 1'b0;
      @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd5 || err_to !== 1'b0) begin
         $display("FAIL timeout_tie: ctrl_E=%0d err_to=%b want 5/0", ctrl_E, err_to); errors++;
      end
      bus_done = 1'b0;
`else
      repeat (300) @(negedge clk);
      checks++;
      if (ctrl_E !== 5'd2 || err_to !== 1'b0) begin
         $display("FAIL no_timeout: ctrl_E=%0d err_to=%b want 2/0", ctrl_E, err_to); errors++;
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (ctrl_E !== 5'd21) begin $display("FAIL no_timeout_abort: got %0d want 21", ctrl_E); errors++; end
`endif
      $display("test_timeout done");
   endtask

   initial begin
      test_reset();
      run_sequence("h24_notimer", 1'b0, 1'b0, 3, 3, 0);
      run_sequence("h12_timer",   1'b1, 1'b1, 0, 2, 0);
      run_sequence("held_start",  1'b0, 1'b1, 1, 1, 10);
      for (int n = 0; n < 6; n++) begin
         run_sequence($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      0, 2, $urandom_range(0, 3));
      end
      test_abort();
      test_async_reset();
      test_ignored();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
